// File: rtl/ls_return_pkg.sv
// Shared types for the load-return tracker: slot record, load funct3 codes
// and the sub-unit index width helper.
package ls_return_pkg;

  localparam logic [2:0] FN3_LB  = 3'b000;
  localparam logic [2:0] FN3_LH  = 3'b001;
  localparam logic [2:0] FN3_LW  = 3'b010;
  localparam logic [2:0] FN3_LBU = 3'b100;
  localparam logic [2:0] FN3_LHU = 3'b101;

  // Slot fields are sized for the widest supported configuration; the
  // tracker zero-extends narrower sub-unit indices and ids into them.
  localparam int SLOT_SU_W = 8;
  localparam int SLOT_ID_W = 8;

  typedef struct packed {
    logic                 valid;
    logic                 returned;
    logic [SLOT_SU_W-1:0] subunit;
    logic [2:0]           fn3;
    logic [1:0]           byte_addr;
    logic [SLOT_ID_W-1:0] id;
    logic [31:0]          data;
  } ls_return_slot_t;

  function automatic int su_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ls_load_align.sv
// Load data alignment and extension: selects the addressed byte/halfword of a
// returned word and sign- or zero-extends it according to funct3.
module ls_load_align
  import ls_return_pkg::*;
(
  input  logic [2:0]  i_fn3,
  input  logic [1:0]  i_byte_addr,
  input  logic [31:0] i_data,
  output logic [31:0] o_result
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  always_comb begin
    w_half = i_byte_addr[1] ? i_data[31:16] : i_data[15:0];
    w_byte = i_byte_addr[0] ? w_half[15:8] : w_half[7:0];
    case (i_fn3)
      FN3_LB:  o_result = {{24{w_byte[7]}}, w_byte};
      FN3_LH:  o_result = {{16{w_half[15]}}, w_half};
      FN3_LBU: o_result = {24'd0, w_byte};
      FN3_LHU: o_result = {16'd0, w_half};
      default: o_result = i_data;
    endcase
  end

endmodule

// File: rtl/ls_load_return_tracker.sv
// In-order retirement of loads whose data comes back out of order from
// several load/store sub-units; CSR results take priority on writeback.
module ls_load_return_tracker
  import ls_return_pkg::*;
#(
  parameter int NUM_SUB_UNITS   = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_W            = 3,
  parameter int SU_W            = su_width(NUM_SUB_UNITS),
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic [SU_W-1:0]             req_subunit,
  input  logic [2:0]                  req_fn3,
  input  logic [1:0]                  req_byte_addr,
  input  logic [ID_W-1:0]             req_id,
  output logic                        req_ready,
  input  logic [NUM_SUB_UNITS-1:0]    unit_data_valid,
  input  logic [NUM_SUB_UNITS*32-1:0] unit_data,
  input  logic                        csr_done,
  input  logic [31:0]                 csr_rd,
  input  logic [ID_W-1:0]             csr_id,
  output logic                        wb_done,
  output logic [31:0]                 wb_rd,
  output logic [ID_W-1:0]             wb_id,
  output logic                        empty,
  output logic [CNT_W-1:0]            count
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);

  ls_return_slot_t         r_slot [MAX_OUTSTANDING];
  logic [PTR_W-1:0]        r_head;
  logic [PTR_W-1:0]        r_tail;
  logic [CNT_W-1:0]        r_count;

  logic [PTR_W-1:0]         w_match_idx [NUM_SUB_UNITS];
  logic [NUM_SUB_UNITS-1:0] w_match_hit;
  logic [PTR_W-1:0]         w_idx;
  logic                     w_full;
  logic                     w_push;
  logic                     w_head_ready;
  logic                     w_retire;
  logic [31:0]              w_aligned;
  logic                     w_unused_id;

  assign w_full       = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_push       = req_valid & ~w_full;
  assign w_head_ready = r_slot[r_head].valid & r_slot[r_head].returned;
  assign w_retire     = w_head_ready & ~csr_done;
  assign w_unused_id  = ^r_slot[r_head].id;

  // Oldest-first search per sub-unit: scanning from the youngest offset down
  // leaves the slot closest to head as the final assignment.
  always_comb begin
    w_match_hit = '0;
    w_idx       = '0;
    for (int u = 0; u < NUM_SUB_UNITS; u++) begin
      w_match_idx[u] = '0;
      for (int k = MAX_OUTSTANDING - 1; k >= 0; k--) begin
        w_idx = r_head + PTR_W'(k);
        if (r_slot[w_idx].valid && !r_slot[w_idx].returned &&
            r_slot[w_idx].subunit == SLOT_SU_W'(u)) begin
          w_match_hit[u] = 1'b1;
          w_match_idx[u] = w_idx;
        end
      end
    end
  end

  ls_load_align u_align (
    .i_fn3       (r_slot[r_head].fn3),
    .i_byte_addr (r_slot[r_head].byte_addr),
    .i_data      (r_slot[r_head].data),
    .o_result    (w_aligned)
  );

  assign req_ready = rst | ~w_full;
  assign empty     = rst | (r_count == '0);
  assign count     = rst ? '0 : r_count;
  assign wb_done   = ~rst & (csr_done | w_head_ready);
  assign wb_rd     = rst ? '0 : csr_done ? csr_rd :
                     w_retire ? w_aligned : '0;
  assign wb_id     = rst ? '0 : csr_done ? csr_id :
                     w_retire ? r_slot[r_head].id[ID_W-1:0] : '0;

  // Push, returns and retire touch distinct slots, so all apply in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_slot[i].valid    <= 1'b0;
        r_slot[i].returned <= 1'b0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_retire) begin
        r_slot[r_head].valid    <= 1'b0;
        r_slot[r_head].returned <= 1'b0;
        r_head                  <= r_head + 1'b1;
      end
      for (int u = 0; u < NUM_SUB_UNITS; u++) begin
        if (unit_data_valid[u] && w_match_hit[u]) begin
          r_slot[w_match_idx[u]].returned <= 1'b1;
          r_slot[w_match_idx[u]].data     <= unit_data[u*32 +: 32];
        end
      end
      if (w_push) begin
        r_slot[r_tail].valid     <= 1'b1;
        r_slot[r_tail].returned  <= 1'b0;
        r_slot[r_tail].subunit   <= SLOT_SU_W'(req_subunit);
        r_slot[r_tail].fn3       <= req_fn3;
        r_slot[r_tail].byte_addr <= req_byte_addr;
        r_slot[r_tail].id        <= SLOT_ID_W'(req_id);
        r_tail                   <= r_tail + 1'b1;
      end
      case ({w_push, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(req_valid && w_full))
        else $error("load pushed while tracker full");
      for (int u = 0; u < NUM_SUB_UNITS; u++) begin
        if (unit_data_valid[u]) begin
          assert (w_match_hit[u])
            else $warning("sub-unit %0d returned data with no outstanding load", u);
        end
      end
    end
  end

endmodule
